parallel_to_serial: RTL and testbench
=====================================

Name: parallel_to_serial

Overview:
- Transmit side of the inter-board serial link; drives the line that serial_to_parallel receives.
- Accepts one byte per handshake and emits a frame: start bit (0), DATA_WIDTH data bits LSB first, STOP_BITS stop bits (1).
- Each bit is held for OVERSAMPLE sample ticks, so the receiver sampling at mid-bit count 7 lands in the bit centre.
- Sits between game logic (move/result encoding) and the board-to-board GPIO pin.

Parameters:
DATA_WIDTH, 8, payload bits per frame
OVERSAMPLE, 16, sample ticks per bit (power of two; counter width = log2)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle oversample enable (16x baud); same source as the receiver's sample counter
data_in  input  DATA_WIDTH  byte to send; captured only on an accepted load
load  input  1  request to send; accepted when load && ready
ready  output  1  high in IDLE; transmitter can accept a byte
serial_out  output  1  line output; idle/stop = 1, start = 0
done  output  1  one-cycle pulse after the last stop bit completes

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, serial_out=1, ready=1, done=0.
  - shift register, tick_cnt and bit_cnt all cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high with no glitch to 0.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - serial_out=1, ready=1.
  - load=1: data_in is latched into the shift register, tick_cnt=0 and bit_cnt=0; next state is START.
  - serial_out goes 0 on the clock after acceptance.
- Bit timing, all active states:
  - tick_cnt increments only on clock edges with tick=1.
  - When tick_cnt==OVERSAMPLE-1 and tick=1, tick_cnt wraps to 0 and the bit period ends.
  - The line never changes between ticks.
- START: serial_out=0. At bit end, go to DATA; serial_out = shreg[0].
- DATA:
  - serial_out=shreg[0].
  - At bit end: shift right, bit_cnt+1.
  - After bit_cnt reaches DATA_WIDTH-1 and that bit ends, go to STOP.
- STOP:
  - serial_out=1.
  - At the end of stop bit number STOP_BITS, go to IDLE and pulse done=1 for exactly one clock (the first IDLE cycle).
- Frame length: (1+DATA_WIDTH+STOP_BITS)*OVERSAMPLE ticks.
- Back-to-back frames: ready=1 during the done cycle, and load in that cycle is accepted. The next start bit follows the full stop period with no extra idle bit.
- Rules for load and data_in:
  - load while ready=0 is ignored; it is not queued.
  - data_in changes after acceptance do not affect the frame in flight.
- tick held low stalls the frame indefinitely; the state and the line are frozen.
- tick and load in the same IDLE cycle: load is accepted, and that tick is not counted toward the start bit.
- Outputs are registered; there is no combinational path from any input to serial_out or done. ready is decoded from the state register.

Decomposition:
- Shared package link_pkg holds:
  - the state enum (IDLE, START, DATA, STOP)
  - LINK_START_BIT=0, LINK_STOP_BIT=1, LINK_IDLE=1
  - the OVERSAMPLE and DATA_WIDTH defaults, so transmitter and receiver agree
  - SAMPLE_POINT=7
- One natural sub-module: baud_tick_gen, a clock divider producing tick. It is instantiated at the top level and shared with serial_to_parallel, not inside this block.

Test Plan:
- Reset then idle: rst_n=0 for 2 clocks, then 1, tick every clock, no load for 50 clocks -> serial_out=1, ready=1, done=0 throughout.
- Single frame: tick every clock, load=1 with data_in=8'hA5 at cycle 0 ->
  - serial_out=0 for cycles 1-16
  - data bits 1,0,1,0,0,1,0,1 for 16 cycles each (cycles 17-144)
  - 1 for cycles 145-160
  - done=1 only at cycle 161, with ready=1 in that cycle
- Loopback: connect serial_out to serial_to_parallel with a shared 4-bit sample counter, send 8'h3C then 8'hFF back-to-back (second load in the done cycle) -> receiver out=8'h3C then 8'hFF, with no idle gap between frames.
- Ignored load: during the DATA state of frame 8'h5A, pulse load with data_in=8'h00 -> frame continues as 5A, and only one done pulse occurs.
- Sparse tick: tick once every 4 clocks, send 8'h81 -> every bit lasts exactly 64 clocks, and the line is stable between ticks.
- Reset mid-frame: assert rst_n=0 asynchronously, mid-clock, during data bit 3 -> serial_out=1 and ready=1 immediately; after release a new load of 8'h12 transmits a clean full frame.

Source files
------------

// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared framing constants and state encoding for the serial link
package link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } link_state_e;

  localparam logic LINK_START_BIT = 1'b0;
  localparam logic LINK_STOP_BIT  = 1'b1;
  localparam logic LINK_IDLE      = 1'b1;

  localparam int LINK_OVERSAMPLE = 16;
  localparam int LINK_DATA_WIDTH = 8;

  // Receiver samples at this oversample count, i.e. the centre of a bit.
  localparam int SAMPLE_POINT = 7;

endpackage

// File: rtl/parallel_to_serial_if.sv
// rtl/parallel_to_serial_if.sv - byte handshake between game logic and the link transmitter
interface parallel_to_serial_if import link_pkg::*; #(
  parameter int DATA_WIDTH = LINK_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  load;
  logic                  ready;
  logic                  done;

  modport master (
    output data_in,
    output load,
    input  ready,
    input  done
  );

  modport slave (
    input  data_in,
    input  load,
    output ready,
    output done
  );

endinterface

// File: rtl/parallel_to_serial_bit_timer.sv
// rtl/parallel_to_serial_bit_timer.sv - counts oversample ticks and flags the end of each bit period
module parallel_to_serial_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  output logic bit_end_o
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] tick_cnt_q;
  logic [CW-1:0] tick_cnt_d;

  // While cleared (idle) ticks are ignored, so a tick coinciding with a load is not counted.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clr_i) begin
      tick_cnt_d = '0;
    end else if (tick_i) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // Counter register; power-of-two OVERSAMPLE lets it wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign bit_end_o = tick_i && !clr_i && (tick_cnt_q == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - link transmitter: start bit, LSB-first payload, stop bits
module parallel_to_serial import link_pkg::*; #(
  parameter int DATA_WIDTH = LINK_DATA_WIDTH,
  parameter int OVERSAMPLE = LINK_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  parallel_to_serial_if.slave   bus,
  output logic                  serial_out
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  link_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]         stop_cnt_q, stop_cnt_d;
  logic                  serial_out_q, serial_out_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  parallel_to_serial_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == IDLE),
    .tick_i    (tick),
    .bit_end_o (bit_end)
  );

  // Next-state and next-output decode; the line value is computed one clock ahead so it is registered.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    serial_out_d = serial_out_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        serial_out_d = LINK_IDLE;
        if (bus.load) begin
          shreg_d      = bus.data_in;
          bit_cnt_d    = '0;
          stop_cnt_d   = '0;
          serial_out_d = LINK_START_BIT;
          state_d      = START;
        end
      end
      START: begin
        if (bit_end) begin
          serial_out_d = shreg_q[0];
          state_d      = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            serial_out_d = LINK_STOP_BIT;
            state_d      = STOP;
          end else begin
            shreg_d      = shreg_q >> 1;
            bit_cnt_d    = bit_cnt_q + 1'b1;
            serial_out_d = shreg_q[1];
          end
        end
      end
      STOP: begin
        serial_out_d = LINK_STOP_BIT;
        if (bit_end) begin
          if (stop_cnt_q == SW'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        serial_out_d = LINK_IDLE;
      end
    endcase
  end

  // State and output registers; reset drives the line straight back to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      serial_out_q <= LINK_IDLE;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      serial_out_q <= serial_out_d;
      done_q       <= done_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = done_q;
  assign serial_out = serial_out_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - directed self-checking bench for parallel_to_serial
module tb_parallel_to_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sparse = 1'b0;
  logic tick;
  logic serial_out;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  parallel_to_serial_if #(.DATA_WIDTH(8)) bus ();

  parallel_to_serial #(
    .DATA_WIDTH(8),
    .OVERSAMPLE(16),
    .STOP_BITS(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .bus        (bus),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tick = sparse ? (cyc[1:0] == 2'd0) : 1'b1;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has just raised load with data d; checks every clock of the frame and the done cycle.
  task automatic frame(input logic [7:0] d, input int per, input bit stray,
                       input bit next_load, input logic [7:0] next_d);
    logic [7:0] rx;
    logic       expb;
    int         idx;
    rx = 8'h00;
    for (int c = 1; c <= 10 * per; c++) begin
      step();
      if (c == 1) begin
        bus.load    = 1'b0;
        bus.data_in = ~d;
      end
      if (stray && c == 5 * per) begin
        bus.load    = 1'b1;
        bus.data_in = 8'h00;
      end else if (stray && c == 5 * per + 1) begin
        bus.load = 1'b0;
      end
      idx = (c - 1) / per;
      if (idx == 0)      expb = 1'b0;
      else if (idx <= 8) expb = d[3'(idx - 1)];
      else               expb = 1'b1;
      chk_bit("line", serial_out, expb);
      chk_bit("done_low", bus.done, 1'b0);
      if (((c - 1) % per) == per / 2 && idx >= 1 && idx <= 8) rx[3'(idx - 1)] = serial_out;
      if (c == 5 * per) chk_bit("ready_busy", bus.ready, 1'b0);
    end
    step();
    chk_bit("done_pulse", bus.done, 1'b1);
    chk_bit("ready_in_done", bus.ready, 1'b1);
    chk_bit("line_after_stop", serial_out, 1'b1);
    chk_byte("rx_byte", rx, d);
    if (next_load) begin
      bus.load    = 1'b1;
      bus.data_in = next_d;
    end
  endtask

  initial begin
    bus.load    = 1'b0;
    bus.data_in = 8'h00;

    // Reset held for two clocks
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_line", serial_out, 1'b1);
    chk_bit("rst_ready", bus.ready, 1'b1);
    chk_bit("rst_done", bus.done, 1'b0);
    rst_n = 1'b1;

    // Idle with ticks, no load
    for (int i = 0; i < 50; i++) begin
      step();
      chk_bit("idle_line", serial_out, 1'b1);
      chk_bit("idle_ready", bus.ready, 1'b1);
      chk_bit("idle_done", bus.done, 1'b0);
    end

    // Single frame A5
    bus.load    = 1'b1;
    bus.data_in = 8'hA5;
    chk_bit("ready_before_load", bus.ready, 1'b1);
    frame(8'hA5, 16, 1'b0, 1'b0, 8'h00);
    step();
    chk_bit("done_one_cycle", bus.done, 1'b0);
    chk_bit("idle_after_frame", serial_out, 1'b1);

    // Back-to-back 3C then FF, second load in the done cycle
    bus.load    = 1'b1;
    bus.data_in = 8'h3C;
    frame(8'h3C, 16, 1'b0, 1'b1, 8'hFF);
    frame(8'hFF, 16, 1'b0, 1'b0, 8'h00);
    step();

    // Load during DATA is ignored
    bus.load    = 1'b1;
    bus.data_in = 8'h5A;
    frame(8'h5A, 16, 1'b1, 1'b0, 8'h00);
    step();
    chk_bit("single_done", bus.done, 1'b0);
    chk_bit("no_queued_frame", serial_out, 1'b1);

    // Sparse tick, load aligned to a ticking edge
    sparse = 1'b1;
    step();
    for (int i = 0; i < 8 && !tick; i++) step();
    chk_bit("tick_align", tick, 1'b1);
    bus.load    = 1'b1;
    bus.data_in = 8'h81;
    frame(8'h81, 64, 1'b0, 1'b0, 8'h00);
    step();
    sparse = 1'b0;
    step();

    // Reset in the middle of data bit 3 of frame C3 (bit 3 is 0)
    bus.load    = 1'b1;
    bus.data_in = 8'hC3;
    step();
    bus.load = 1'b0;
    for (int c = 2; c <= 1 + 4 * 16 + 8; c++) step();
    chk_bit("pre_reset_line", serial_out, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_bit("async_rst_line", serial_out, 1'b1);
    chk_bit("async_rst_ready", bus.ready, 1'b1);
    chk_bit("async_rst_done", bus.done, 1'b0);
    repeat (2) begin
      step();
      chk_bit("rst_hold_line", serial_out, 1'b1);
    end
    rst_n = 1'b1;
    step();
    chk_bit("post_rst_line", serial_out, 1'b1);
    chk_bit("post_rst_ready", bus.ready, 1'b1);
    bus.load    = 1'b1;
    bus.data_in = 8'h12;
    frame(8'h12, 16, 1'b0, 1'b0, 8'h00);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
